// File: rtl/led_bank_ctrl.sv
// led_bank_ctrl: NUM_CH LED channels (off / on / PWM / blink) behind one 256-word register page.
// Latency: register updated 3 Clk after Wr falls, Led follows 1 Clk later; DataRd/Hit combinational.
// Backpressure: none; exactly one commit per Wr strobe, strobes spaced wider than the synchroniser.
module led_bank_ctrl #(
  parameter int unsigned NUM_CH     = 4,
  parameter logic [15:0] BASE_PAGE  = 16'hffe2,
  parameter int unsigned PRESCALE   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [23:0]       Addr,
  input  logic              Wr,
  input  logic [15:0]       WrData,
  output logic [15:0]       DataRd,
  output logic              Hit,
  output logic [NUM_CH-1:0] Led
);

  localparam int unsigned       PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]        OFF_GLOBAL = 8'h20;
  localparam logic [7:0]        OFF_TICKS  = 8'h21;
  localparam logic [NUM_CH-1:0] LED_DARK   = {NUM_CH{ACTIVE_LOW}};

  // ------------------------------------------------------------------
  // Write strobe synchroniser and bus capture
  // ------------------------------------------------------------------
  logic        wr_meta_q, wr_sync_q, wr_dly_q;
  logic [23:0] addr_smp_q;
  logic [15:0] data_smp_q;

  // Two flops bring Wr into the Clk domain; a third copy gives the falling-edge detect
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_meta_q <= 1'b0;
      wr_sync_q <= 1'b0;
      wr_dly_q  <= 1'b0;
    end else begin
      wr_meta_q <= Wr;
      wr_sync_q <= wr_meta_q;
      wr_dly_q  <= wr_sync_q;
    end
  end

  // Capture the bus every Clk while the synchronised strobe is high; the last capture commits
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_smp_q <= '0;
      data_smp_q <= '0;
    end else if (wr_sync_q) begin
      addr_smp_q <= Addr;
      data_smp_q <= WrData;
    end
  end

  // ------------------------------------------------------------------
  // Write decode
  // ------------------------------------------------------------------
  logic       commit;
  logic       smp_hit;
  logic [7:0] wr_off;
  logic [2:0] wr_ch;
  logic       ch_wr;
  logic       global_wr;
  logic       restart;

  assign commit    = wr_dly_q & ~wr_sync_q;
  assign smp_hit   = (addr_smp_q[23:8] == BASE_PAGE);
  assign wr_off    = addr_smp_q[7:0];
  assign wr_ch     = wr_off[3:1];
  // Channel range check happens in the per-channel loop: no channel matches wr_ch >= NUM_CH
  assign ch_wr     = commit & smp_hit & (wr_off[7:4] == 4'd0);
  assign global_wr = commit & smp_hit & (wr_off == OFF_GLOBAL);
  assign restart   = global_wr & data_smp_q[1];

  // ------------------------------------------------------------------
  // Global state: enable, prescaler, PWM counter, tick counter
  // ------------------------------------------------------------------
  logic          enable_q, enable_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    pwm_q, pwm_d;
  logic [15:0]   ticks_q, ticks_d;
  logic          tick;

  assign tick = (presc_q == PRESC_LAST);

  // Free-running counters; a restart pulse zeroes all of them in the same Clk
  always_comb begin
    enable_d = enable_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);
    pwm_d    = pwm_q + 8'd1;
    ticks_d  = tick ? ticks_q + 16'd1 : ticks_q;
    if (global_wr) begin
      enable_d = data_smp_q[0];
    end
    if (restart) begin
      presc_d = '0;
      pwm_d   = '0;
      ticks_d = '0;
    end
  end

  // Global state registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      enable_q <= 1'b0;
      presc_q  <= '0;
      pwm_q    <= '0;
      ticks_q  <= '0;
    end else begin
      enable_q <= enable_d;
      presc_q  <= presc_d;
      pwm_q    <= pwm_d;
      ticks_q  <= ticks_d;
    end
  end

  // ------------------------------------------------------------------
  // Per-channel configuration and blink state
  // ------------------------------------------------------------------
  logic [NUM_CH-1:0][1:0] mode_q, mode_d;
  logic [NUM_CH-1:0][7:0] duty_q, duty_d;
  logic [NUM_CH-1:0][7:0] on_q, on_d;
  logic [NUM_CH-1:0][7:0] off_q, off_d;
  logic [NUM_CH-1:0][7:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]      phase_off_q, phase_off_d;   // 0 = ON phase, so reset lands in ON

  // Register writes and blink stepping; a write to a channel overrides a coincident tick
  always_comb begin
    mode_d      = mode_q;
    duty_d      = duty_q;
    on_d        = on_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    phase_off_d = phase_off_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_wr && (wr_ch == 3'(i))) begin
        if (!wr_off[0]) begin
          mode_d[i] = data_smp_q[1:0];
          duty_d[i] = data_smp_q[15:8];
        end else begin
          on_d[i]  = data_smp_q[7:0];
          off_d[i] = data_smp_q[15:8];
        end
        phase_off_d[i] = 1'b0;
        cnt_d[i]       = '0;
      end else if (restart) begin
        phase_off_d[i] = 1'b0;
        cnt_d[i]       = '0;
      end else if (tick) begin
        if ((cnt_q[i] + 8'd1) == (phase_off_q[i] ? off_q[i] : on_q[i])) begin
          phase_off_d[i] = ~phase_off_q[i];
          cnt_d[i]       = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Per-channel registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mode_q      <= '0;
      duty_q      <= '0;
      on_q        <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      phase_off_q <= '0;
    end else begin
      mode_q      <= mode_d;
      duty_q      <= duty_d;
      on_q        <= on_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      phase_off_q <= phase_off_d;
    end
  end

  // ------------------------------------------------------------------
  // Output: mode function gated by the global enable, then registered
  // ------------------------------------------------------------------
  logic [NUM_CH-1:0] lit;
  logic [NUM_CH-1:0] led_q;

  // Evaluate each channel's mode function; duty FF is full-on rather than 255/256
  always_comb begin
    lit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (mode_q[i])
        2'd0: lit[i] = 1'b0;
        2'd1: lit[i] = 1'b1;
        2'd2: lit[i] = (duty_q[i] == 8'hFF) | (pwm_q < duty_q[i]);
        2'd3: lit[i] = (on_q[i] != 8'd0) & ((off_q[i] == 8'd0) | ~phase_off_q[i]);
        default: lit[i] = 1'b0;
      endcase
      lit[i] = lit[i] & enable_q;
    end
  end

  // Register the LED drive with the board polarity applied
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      led_q <= LED_DARK;
    end else begin
      led_q <= ACTIVE_LOW ? ~lit : lit;
    end
  end

  assign Led = led_q;

  // ------------------------------------------------------------------
  // Read path
  // ------------------------------------------------------------------
  logic [7:0] rd_off;
  logic [2:0] rd_ch;

  assign Hit    = (Addr[23:8] == BASE_PAGE);
  assign rd_off = Addr[7:0];
  assign rd_ch  = rd_off[3:1];

  // Combinational readback; unmapped offsets and channels >= NUM_CH return zero
  always_comb begin
    DataRd = '0;
    if (Hit) begin
      if (rd_off == OFF_GLOBAL) begin
        DataRd = {15'd0, enable_q};
      end else if (rd_off == OFF_TICKS) begin
        DataRd = ticks_q;
      end else if (rd_off[7:4] == 4'd0) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (rd_ch == 3'(i)) begin
            DataRd = rd_off[0] ? {off_q[i], on_q[i]} : {duty_q[i], 6'd0, mode_q[i]};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_bank_ctrl.sv
module tb_led_bank_ctrl;
  localparam int          NCH  = 4;
  localparam int          P    = 4;
  localparam logic [15:0] PAGE = 16'hffe2;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [23:0]    Addr;
  logic           Wr;
  logic [15:0]    WrData;
  logic [15:0]    DataRd;
  logic           Hit;
  logic [NCH-1:0] Led;

  led_bank_ctrl #(.NUM_CH(NCH), .BASE_PAGE(PAGE), .PRESCALE(P), .ACTIVE_LOW(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .Wr(Wr), .WrData(WrData),
    .DataRd(DataRd), .Hit(Hit), .Led(Led)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_n = Clk edges since reset/restart; PWM = n mod 256, ticks done = n / P.
  // A blink channel has seen (n/P - start/P) ticks since its last write/restart,
  // and is lit while that count mod (on+off) is below on.
  int          m_n;
  logic        m_en;
  logic [1:0]  m_mode [NCH];
  logic [7:0]  m_duty [NCH];
  logic [7:0]  m_on   [NCH];
  logic [7:0]  m_off  [NCH];
  int          m_start[NCH];
  logic [NCH-1:0] exp_led;
  logic [NCH-1:0] lit_v;
  int          req_cnt = 0, seen_cnt = 0, pend = 0;
  logic [23:0] req_addr, pend_addr;
  logic [15:0] req_data, pend_data;
  bit          cmp_en = 0;

  task automatic model_clear();
    m_n  = 0;
    m_en = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = '0; m_duty[i] = '0; m_on[i] = '0; m_off[i] = '0; m_start[i] = 0;
    end
  endtask

  task automatic model_commit(input logic [23:0] a, input logic [15:0] d);
    int o;
    int ch;
    o = int'(a[7:0]);
    if (a[23:8] == PAGE) begin
      if (o < 2 * NCH) begin
        ch = o / 2;
        if (o % 2 == 0) begin m_mode[ch] = d[1:0]; m_duty[ch] = d[15:8]; end
        else            begin m_on[ch]   = d[7:0]; m_off[ch]  = d[15:8]; end
        m_start[ch] = m_n;
      end else if (o == 8'h20) begin
        m_en = d[0];
        if (d[1]) begin
          m_n = 0;
          for (int i = 0; i < NCH; i++) m_start[i] = 0;
        end
      end
    end
  endtask

  function automatic logic model_lit(input int ch);
    int k;
    int per;
    if (!m_en) return 1'b0;
    case (m_mode[ch])
      2'd0: return 1'b0;
      2'd1: return 1'b1;
      2'd2: return (m_duty[ch] == 8'hFF) || ((m_n % 256) < int'(m_duty[ch]));
      default: begin
        if (m_on[ch] == 8'd0)  return 1'b0;
        if (m_off[ch] == 8'd0) return 1'b1;
        k   = m_n / P - m_start[ch] / P;
        per = int'(m_on[ch]) + int'(m_off[ch]);
        return (k % per) < int'(m_on[ch]);
      end
    endcase
  endfunction

  function automatic logic [15:0] model_read(input logic [23:0] a);
    int o;
    int ch;
    o = int'(a[7:0]);
    if (a[23:8] != PAGE) return 16'h0000;
    if (o == 8'h20) return {15'd0, m_en};
    if (o == 8'h21) return 16'((m_n / P) % 65536);
    if (o < 2 * NCH) begin
      ch = o / 2;
      if (o % 2 == 0) return {m_duty[ch], 6'd0, m_mode[ch]};
      return {m_off[ch], m_on[ch]};
    end
    return 16'h0000;
  endfunction

  // Model advances once per Clk edge; a write commits on the 3rd edge after Wr falls
  always @(posedge Clk) begin
    if (Reset) begin
      model_clear();
      seen_cnt = req_cnt;
      pend     = 0;
      exp_led  = '1;
    end else begin
      for (int i = 0; i < NCH; i++) lit_v[i] = model_lit(i);
      exp_led = ~lit_v;
      if (req_cnt != seen_cnt) begin
        seen_cnt  = req_cnt;
        pend      = 3;
        pend_addr = req_addr;
        pend_data = req_data;
      end
      m_n = m_n + 1;
      if (pend > 0) begin
        pend--;
        if (pend == 0) model_commit(pend_addr, pend_data);
      end
    end
  end

  // Cycle-by-cycle comparison of the LED outputs
  always @(negedge Clk) begin
    if (cmp_en && !Reset) chk("led", 32'(Led), 32'(exp_led));
  end

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [23:0] a, input logic [15:0] d, input int hold);
    @(negedge Clk);
    Addr = a; WrData = d; Wr = 1'b1;
    repeat (hold) @(negedge Clk);
    Wr = 1'b0;
    req_addr = a; req_data = d; req_cnt++;
    repeat (4) @(negedge Clk);
  endtask

  task automatic bus_read(input logic [23:0] a, input string name);
    @(negedge Clk);
    Addr = a;
    #1;
    chk({name, "_rd"}, 32'(DataRd), 32'(model_read(a)));
    chk({name, "_hit"}, 32'(Hit), 32'(a[23:8] == PAGE));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          cnt;
    int          runs[$];
    logic        cur;
    logic        first_lvl;
    int          len;
    bit          found;
    int          ch, kind, sel;
    logic [7:0]  off, duty;
    logic [15:0] d, page;

    Reset = 1'b1; Wr = 1'b0; Addr = '0; WrData = '0;
    repeat (3) @(negedge Clk);
    chk("rst_led", 32'(Led), 32'hF);
    Reset = 1'b0;
    cmp_en = 1;

    // Reset map and page decode
    for (int o = 0; o < 256; o++) bus_read({PAGE, 8'(o)}, "reset_map");
    @(negedge Clk);
    Addr = {16'hffe3, 8'h20}; #1;
    chk("hit_other_page", 32'(Hit), 32'd0);
    chk("rd_other_page", 32'(DataRd), 32'd0);
    Addr = {PAGE, 8'h00}; #1;
    chk("hit_base_page", 32'(Hit), 32'd1);
    chk("ctrl0_after_rst", 32'(DataRd), 32'd0);

    // Static on/off
    bus_write({PAGE, 8'h20}, 16'h0001, 2);
    bus_write({PAGE, 8'h00}, 16'h0001, 2);
    chk("led0_on", 32'(Led[0]), 32'd0);
    bus_write({PAGE, 8'h02}, 16'h0000, 2);
    chk("led1_off", 32'(Led[1]), 32'd1);
    @(negedge Clk);
    Addr = {PAGE, 8'h00}; #1;
    chk("ctrl0_readback", 32'(DataRd), 32'h0001);

    // PWM duty cycles over one full period
    bus_write({PAGE, 8'h04}, 16'h4002, 1);
    cnt = 0;
    repeat (256) begin @(negedge Clk); if (!Led[2]) cnt++; end
    chk("pwm_duty64", cnt, 64);
    bus_write({PAGE, 8'h04}, 16'h0002, 3);
    cnt = 0;
    repeat (256) begin @(negedge Clk); if (!Led[2]) cnt++; end
    chk("pwm_duty00", cnt, 0);
    bus_write({PAGE, 8'h04}, 16'hFF02, 4);
    cnt = 0;
    repeat (256) begin @(negedge Clk); if (!Led[2]) cnt++; end
    chk("pwm_dutyFF", cnt, 256);

    // Blink: 2 ticks on, 3 ticks off at 4 Clk per tick
    bus_write({PAGE, 8'h07}, 16'h0302, 2);
    bus_write({PAGE, 8'h06}, 16'h0003, 2);
    first_lvl = Led[3];
    cur = Led[3]; len = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge Clk);
      if (Led[3] == cur) len++;
      else begin runs.push_back(len); cur = Led[3]; len = 1; end
    end
    chk("blink_starts_lit", 32'(first_lvl), 32'd0);
    chk("blink_off_run", (runs.size() > 3) ? runs[1] : -1, 12);
    chk("blink_on_run", (runs.size() > 3) ? runs[2] : -1, 8);
    chk("blink_off_run2", (runs.size() > 3) ? runs[3] : -1, 12);

    // Rewrite BLINK_3 during the off phase: the on phase restarts
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge Clk);
      if (Led[3]) found = 1;
    end
    chk("blink_off_seen", 32'(found), 32'd1);
    repeat (2) @(negedge Clk);
    bus_write({PAGE, 8'h07}, 16'h0302, 1);
    chk("blink_rewrite_on", 32'(Led[3]), 32'd0);

    // Asynchronous reset in the middle of a Wr strobe
    chk("pre_rst_led0", 32'(Led[0]), 32'd0);
    @(negedge Clk);
    Addr = {PAGE, 8'h02}; WrData = 16'h5503; Wr = 1'b1;
    repeat (3) @(negedge Clk);
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1 chk("rst_async_led", 32'(Led), 32'hF);
    Wr = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (8) @(negedge Clk);
    Addr = {PAGE, 8'h02}; #1;
    chk("rst_no_commit", 32'(DataRd), 32'd0);
    chk("rst_led_dark", 32'(Led), 32'hF);
    for (int o = 0; o < 2 * NCH; o++) bus_read({PAGE, 8'(o)}, "post_rst");

    // Restart re-aligns all blink channels
    bus_write({PAGE, 8'h20}, 16'h0001, 1);
    bus_write({PAGE, 8'h01}, 16'h0201, 1);
    bus_write({PAGE, 8'h00}, 16'h0003, 2);
    bus_write({PAGE, 8'h03}, 16'h0403, 3);
    bus_write({PAGE, 8'h02}, 16'h0003, 1);
    bus_write({PAGE, 8'h05}, 16'h0105, 2);
    bus_write({PAGE, 8'h04}, 16'h0003, 4);
    bus_write({PAGE, 8'h07}, 16'h0302, 1);
    bus_write({PAGE, 8'h06}, 16'h0003, 2);
    repeat (13) @(negedge Clk);
    bus_write({PAGE, 8'h20}, 16'h0003, 2);
    chk("restart_all_lit", 32'(Led), 32'h0);
    @(negedge Clk);
    Addr = {PAGE, 8'h21}; #1;
    chk("restart_ticks0", 32'(DataRd), 32'd0);
    Addr = {PAGE, 8'h20}; #1;
    chk("global_readback", 32'(DataRd), 32'h0001);

    // Randomised register traffic against the model
    for (int it = 0; it < 40; it++) begin
      ch   = $urandom_range(0, NCH - 1);
      kind = $urandom_range(0, 9);
      page = PAGE;
      case (kind)
        0, 1, 2, 3: begin
          off  = 8'(2 * ch);
          sel  = $urandom_range(0, 3);
          duty = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
          d    = {duty, 6'($urandom), 2'($urandom)};
        end
        4, 5, 6, 7: begin
          off = 8'(2 * ch + 1);
          d   = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))};
        end
        8: begin
          off = 8'h20;
          d   = {14'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0)};
        end
        default: begin
          off = 8'($urandom_range(8, 255));
          d   = 16'($urandom);
          if ($urandom_range(0, 1) == 1) begin
            page = 16'hffe3;
            off  = 8'($urandom_range(0, 7));
          end
        end
      endcase
      bus_write({page, off}, d, $urandom_range(1, 4));
      repeat ($urandom_range(0, 30)) @(negedge Clk);
      bus_read({PAGE, off}, "rand_reg");
      bus_read({PAGE, 8'($urandom_range(0, 40))}, "rand_any");
    end

    repeat (20) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
